plot_arbiter: RTL and testbench

Round-robin scheduler that shares the single VGA adapter plot port among N drawing engines (fillscreen, circle, reuleaux, …). It issues each engine's `start` and holds it through the engine's start/done handshake. It muxes only the granted engine's pixel stream onto `vga_x`/`vga_y`/`vga_colour`/`vga_plot`, so engines never contend for the frame buffer. It sits between the engine instances and the VGA adapter in the top-level task module.

---
 rtl/draw_pkg.sv | 20 ++
 rtl/rr_pick.sv | 33 +++
 rtl/plot_arbiter.sv | 142 ++++++++++++++
 tb/tb_plot_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Types and widths shared by the drawing engines and the plot-port arbiter.
package draw_pkg;

    localparam int unsigned VGA_X_W = 8;
    localparam int unsigned VGA_Y_W = 7;
    localparam int unsigned VGA_C_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RUN,
        ARB_RELEASE
    } arb_state_t;

    typedef struct packed {
        logic [VGA_X_W-1:0] x;
        logic [VGA_Y_W-1:0] y;
        logic [VGA_C_W-1:0] colour;
    } pixel_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1, wrapping.
module rr_pick #(
    parameter int unsigned N_ENG = 3
) (
    input  logic [N_ENG-1:0]         req,
    input  logic [$clog2(N_ENG)-1:0] last,
    output logic [N_ENG-1:0]         pick,
    output logic                     valid
);

    localparam int unsigned IDX_W = $clog2(N_ENG);

    always_comb begin
        int unsigned cand;
        cand  = 0;
        pick  = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < N_ENG; i++) begin
            // last < N_ENG and i < N_ENG, so one subtraction is enough to wrap
            cand = 32'(last) + i + 32'd1;
            if (cand >= N_ENG) begin
                cand = cand - N_ENG;
            end
            for (int unsigned j = 0; j < N_ENG; j++) begin
                if (!valid && (j == cand) && req[IDX_W'(j)]) begin
                    pick[IDX_W'(j)] = 1'b1;
                    valid           = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin owner of the single VGA plot port; runs one engine job at a time
// and forwards only the granted engine's pixel stream, one register stage deep.
module plot_arbiter
    import draw_pkg::*;
#(
    parameter int unsigned N_ENG = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_ENG-1:0]           req,
    output logic [N_ENG-1:0]           ack,
    output logic                       busy,
    output logic [N_ENG-1:0]           grant,
    output logic [N_ENG-1:0]           eng_start,
    input  logic [N_ENG-1:0]           eng_done,
    input  logic [N_ENG*VGA_X_W-1:0]   eng_x,
    input  logic [N_ENG*VGA_Y_W-1:0]   eng_y,
    input  logic [N_ENG*VGA_C_W-1:0]   eng_colour,
    input  logic [N_ENG-1:0]           eng_plot,
    output logic [VGA_X_W-1:0]         vga_x,
    output logic [VGA_Y_W-1:0]         vga_y,
    output logic [VGA_C_W-1:0]         vga_colour,
    output logic                       vga_plot
);

    localparam int unsigned IDX_W = $clog2(N_ENG);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [N_ENG-1:0] grant_q, grant_d;
    logic [N_ENG-1:0] start_q, start_d;
    logic [N_ENG-1:0] ack_q, ack_d;
    logic             busy_q, busy_d;
    pixel_t           pix_q, pix_d;
    logic             plot_q, plot_d;

    logic [N_ENG-1:0] pick;
    logic             pick_valid;
    logic [IDX_W-1:0] g_idx;
    pixel_t           pix_mux;
    logic             plot_mux;
    logic             done_g;

    rr_pick #(.N_ENG(N_ENG)) u_pick (
        .req   (req),
        .last  (last_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    // AND-OR mux over the one-hot grant; non-granted engines contribute zero
    always_comb begin
        g_idx   = '0;
        pix_mux = '0;
        for (int unsigned j = 0; j < N_ENG; j++) begin
            if (grant_q[IDX_W'(j)]) begin
                g_idx = g_idx | IDX_W'(j);
            end
            pix_mux.x      = pix_mux.x      | (eng_x[j*VGA_X_W +: VGA_X_W]      & {VGA_X_W{grant_q[IDX_W'(j)]}});
            pix_mux.y      = pix_mux.y      | (eng_y[j*VGA_Y_W +: VGA_Y_W]      & {VGA_Y_W{grant_q[IDX_W'(j)]}});
            pix_mux.colour = pix_mux.colour | (eng_colour[j*VGA_C_W +: VGA_C_W] & {VGA_C_W{grant_q[IDX_W'(j)]}});
        end
    end

    assign plot_mux = |(eng_plot & grant_q);
    assign done_g   = |(eng_done & grant_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        start_d = start_q;
        ack_d   = '0;
        pix_d   = pix_q;
        plot_d  = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick;
                    start_d = pick;
                    state_d = ARB_RUN;
                end
            end
            ARB_RUN: begin
                pix_d  = pix_mux;
                plot_d = plot_mux;
                if (done_g) begin
                    start_d = '0;
                    ack_d   = grant_q;
                    last_d  = g_idx;
                    plot_d  = 1'b0;
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                // Hold ownership until the engine's done falls, so a stale done never completes the next job
                if (!done_g) begin
                    grant_d = '0;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                start_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            last_q  <= IDX_W'(N_ENG - 1);
            grant_q <= '0;
            start_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            pix_q   <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            start_q <= start_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            pix_q   <= pix_d;
            plot_q  <= plot_d;
        end
    end

    assign ack        = ack_q;
    assign busy       = busy_q;
    assign grant      = grant_q;
    assign eng_start  = start_q;
    assign vga_x      = pix_q.x;
    assign vga_y      = pix_q.y;
    assign vga_colour = pix_q.colour;
    assign vga_plot   = plot_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Directed bench for plot_arbiter with three engines driven by hand from one initial block.
module tb_plot_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  ack;
    logic        busy;
    logic [2:0]  grant;
    logic [2:0]  eng_start;
    logic [2:0]  eng_done = '0;
    logic [23:0] eng_x = '0;
    logic [20:0] eng_y = '0;
    logic [8:0]  eng_colour = '0;
    logic [2:0]  eng_plot = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    int checks = 0;
    int errors = 0;

    plot_arbiter #(.N_ENG(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .ack        (ack),
        .busy       (busy),
        .grant      (grant),
        .eng_start  (eng_start),
        .eng_done   (eng_done),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .eng_colour (eng_colour),
        .eng_plot   (eng_plot),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int e, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input logic p);
        eng_x[e*8 +: 8]      = x;
        eng_y[e*7 +: 7]      = y;
        eng_colour[e*3 +: 3] = c;
        eng_plot[e]          = p;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_start"}, 32'(eng_start), 32'd0);
        chk({tag, "_ack"}, 32'(ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_vx"}, 32'(vga_x), 32'd0);
        chk({tag, "_vy"}, 32'(vga_y), 32'd0);
        chk({tag, "_vc"}, 32'(vga_colour), 32'd0);
        chk({tag, "_vplot"}, 32'(vga_plot), 32'd0);
    endtask

    // Grant, immediate done, release: the engine in exp completes on its first RUN cycle
    task automatic job(input string tag, input logic [2:0] exp);
        tick();
        chk({tag, "_grant"}, 32'(grant), 32'(exp));
        chk({tag, "_start"}, 32'(eng_start), 32'(exp));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        eng_done = exp;
        tick();
        chk({tag, "_ack"}, 32'(ack), 32'(exp));
        chk({tag, "_start_drop"}, 32'(eng_start), 32'd0);
        chk({tag, "_plot_rel"}, 32'(vga_plot), 32'd0);
        eng_done = '0;
        tick();
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_grant"}, 32'(grant), 32'd0);
        chk({tag, "_ack_once"}, 32'(ack), 32'd0);
        chk({tag, "_plot_idle"}, 32'(vga_plot), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_all_zero("rst");
        rst = 1'b0;

        // Single job on engine 2; engine 0 stays non-granted but plots (159,119) throughout
        set_pix(0, 8'd159, 7'd119, 3'd7, 1'b1);
        req = 3'b100;
        tick();
        chk("s_grant", 32'(grant), 32'b100);
        chk("s_start", 32'(eng_start), 32'b100);
        chk("s_busy", 32'(busy), 32'd1);
        chk("s_plot_first", 32'(vga_plot), 32'd0);
        req = 3'b000;
        for (int i = 0; i < 5; i++) begin
            set_pix(2, 8'(80 + i), 7'd60, 3'b001, 1'b1);
            tick();
            chk("s_vx", 32'(vga_x), 32'(80 + i));
            chk("s_vy", 32'(vga_y), 32'd60);
            chk("s_vc", 32'(vga_colour), 32'd1);
            chk("s_vplot", 32'(vga_plot), 32'd1);
        end
        set_pix(2, 8'd84, 7'd60, 3'b001, 1'b0);
        eng_done = 3'b100;
        tick();
        chk("s_ack", 32'(ack), 32'b100);
        chk("s_start_drop", 32'(eng_start), 32'd0);
        chk("s_plot_rel", 32'(vga_plot), 32'd0);
        chk("s_busy_rel", 32'(busy), 32'd1);
        chk("s_vx_rel", 32'(vga_x), 32'd84);
        eng_done = 3'b000;
        tick();
        chk("s_ack_once", 32'(ack), 32'd0);
        chk("s_busy_idle", 32'(busy), 32'd0);
        chk("s_grant_idle", 32'(grant), 32'd0);
        chk("s_plot_idle", 32'(vga_plot), 32'd0);
        set_pix(0, 8'd0, 7'd0, 3'd0, 1'b0);

        // Simultaneous requests rotate 0,1,2,0
        req = 3'b111;
        job("rr0", 3'b001);
        job("rr1", 3'b010);
        job("rr2", 3'b100);
        job("rr3", 3'b001);
        req = 3'b000;

        // Sticky done on engine 1 while it keeps requesting
        req = 3'b010;
        tick();
        chk("k_grant", 32'(grant), 32'b010);
        eng_done = 3'b010;
        tick();
        chk("k_ack", 32'(ack), 32'b010);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("k_rel_busy", 32'(busy), 32'd1);
            chk("k_rel_grant", 32'(grant), 32'b010);
            chk("k_rel_start", 32'(eng_start), 32'd0);
            chk("k_rel_ack", 32'(ack), 32'd0);
        end
        eng_done = 3'b000;
        tick();
        chk("k_idle_busy", 32'(busy), 32'd0);
        chk("k_idle_grant", 32'(grant), 32'd0);
        tick();
        chk("k_regrant", 32'(grant), 32'b010);
        req = 3'b000;
        eng_done = 3'b010;
        tick();
        chk("k_ack2", 32'(ack), 32'b010);
        eng_done = 3'b000;
        tick();
        chk("k_idle2", 32'(busy), 32'd0);

        // Request drop mid-RUN does not abort the job
        req = 3'b001;
        tick();
        chk("d_grant", 32'(grant), 32'b001);
        tick();
        tick();
        req = 3'b000;
        tick();
        chk("d_still_busy", 32'(busy), 32'd1);
        chk("d_still_start", 32'(eng_start), 32'b001);
        eng_done = 3'b001;
        tick();
        chk("d_ack", 32'(ack), 32'b001);
        eng_done = 3'b000;
        tick();
        chk("d_idle", 32'(busy), 32'd0);
        tick();
        tick();
        chk("d_no_regrant", 32'(grant), 32'd0);
        chk("d_no_busy", 32'(busy), 32'd0);

        // Reset in the middle of engine 2's job
        req = 3'b100;
        tick();
        chk("r_grant", 32'(grant), 32'b100);
        req = 3'b000;
        set_pix(2, 8'd33, 7'd22, 3'd5, 1'b1);
        tick();
        chk("r_vx", 32'(vga_x), 32'd33);
        chk("r_vplot", 32'(vga_plot), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("r_async");
        set_pix(2, 8'd0, 7'd0, 3'd0, 1'b0);
        tick();
        rst = 1'b0;
        req = 3'b110;
        tick();
        chk("r_grant_after", 32'(grant), 32'b010);
        req = 3'b000;
        eng_done = 3'b010;
        tick();
        chk("r_ack_after", 32'(ack), 32'b010);
        eng_done = 3'b000;
        tick();
        chk("r_idle_after", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
